// File: rtl/ff_mode_pkg.sv
// ff_mode_pkg: flip-flop behaviour modes shared by the register bank, counters and control FSMs.
package ff_mode_pkg;
    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_JK = 2'b01,
        MODE_T  = 2'b10,
        MODE_SR = 2'b11
    } mode_e;
endpackage

// File: rtl/ff_mode_cell.sv
// ff_mode_cell: next-state logic for one bit acting as a D, JK, T or SR flip-flop.
module ff_mode_cell
    import ff_mode_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_next,
    output logic       illegal
);
    // b is never consulted in D/T so an unknown b cannot reach q there
    always_comb begin
        illegal = mode == MODE_SR && a && b;
        q_next  = mode == MODE_D ? a :
                  mode == MODE_T ? q ^ a :
                  (a && b)       ? (mode == MODE_JK ? ~q : q) :
                  a              ? 1'b1 :
                  b              ? 1'b0 : q;
    end
endmodule

// File: rtl/ff_mode_reg.sv
// ff_mode_reg: WIDTH-bit register whose bits act as D/JK/T/SR flip-flops selected at run time,
// with clock enable, change-detect pulse and sticky SR-illegal reporting.
module ff_mode_reg
    import ff_mode_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             changed,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_mask
);
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            ff_mode_cell u_cell (
                .mode    (mode),
                .a       (a[i]),
                .b       (b[i]),
                .q       (q[i]),
                .q_next  (q_next[i]),
                .illegal (illegal[i])
            );
        end
    endgenerate
    assign qbar = ~q;
    // a fresh illegal input on the clearing edge survives the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            changed  <= 1'b0;
            sr_err   <= 1'b0;
            err_mask <= '0;
        end else begin
            if (en)
                q <= q_next;
            changed  <= en && (q_next != q);
            sr_err   <= (err_clr ? 1'b0 : sr_err) | (en && |illegal);
            err_mask <= (err_clr ? '0 : err_mask) | (en ? illegal : '0);
        end
    end
endmodule
